// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button debouncing, run/pause FSM, tenth-second enable,
// direction latch, counter clear strobe and lap-hold display mux.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 10_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       lap_btn,
  input  logic       clr_btn,
  input  logic       dir_sw,
  input  logic [3:0] min_in,
  input  logic [3:0] secmsd_in,
  input  logic [3:0] seclsd_in,
  input  logic [3:0] ten_in,
  output logic       en,
  output logic       up,
  output logic       clr,
  output logic [3:0] min_out,
  output logic [3:0] secmsd_out,
  output logic [3:0] seclsd_out,
  output logic [3:0] ten_out,
  output logic       dot,
  output logic [1:0] state
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Button bit order everywhere: [0] start, [1] lap, [2] clr.
  logic [2:0]    raw, sync1, sync2, level, level_d, press;
  logic [DW-1:0] deb_cnt [3];

  assign raw = {clr_btn, lap_btn, start_btn};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 3; i++) begin
        // Any sample equal to the accepted level restarts the stability run.
        if (sync2[i] != level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            level[i]   <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  logic clr_p, start_p, lap_p;
  assign clr_p   = press[2];
  assign start_p = press[0] & ~press[2];
  assign lap_p   = press[1] & ~press[0] & ~press[2];

  logic [15:0] live, lap_q;
  logic        at_max, at_zero, term_sw, term_run, tick, lap_active;
  logic [PW-1:0] pre;
  state_t      st;

  assign live     = {min_in, secmsd_in, seclsd_in, ten_in};
  assign at_max   = (live == 16'h9599);
  assign at_zero  = (live == 16'h0000);
  assign term_sw  = dir_sw ? at_max : at_zero;
  assign term_run = up ? at_max : at_zero;
  assign tick     = (pre == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= IDLE;
      en         <= 1'b0;
      up         <= 1'b1;
      clr        <= 1'b1;
      lap_active <= 1'b0;
      lap_q      <= '0;
      pre        <= '0;
    end else begin
      en  <= 1'b0;
      clr <= 1'b0;
      if (lap_p && lap_active) lap_active <= 1'b0;
      case (st)
        IDLE: begin
          if (clr_p) begin
            clr        <= 1'b1;
            lap_active <= 1'b0;
          end else if (start_p && !term_sw) begin
            up  <= dir_sw;
            pre <= '0;
            st  <= RUN;
          end
        end
        RUN: begin
          if (tick) begin
            pre <= '0;
            if (term_run) st <= DONE;
            else          en <= 1'b1;
          end else begin
            pre <= pre + 1'b1;
          end
          // Reaching terminal on the same tick wins over a pause request.
          if (start_p && !(tick && term_run)) st <= PAUSED;
          if (lap_p && !lap_active) begin
            lap_q      <= live;
            lap_active <= 1'b1;
          end
        end
        PAUSED: begin
          if (clr_p) begin
            clr        <= 1'b1;
            lap_active <= 1'b0;
            st         <= IDLE;
          end else if (start_p && !term_sw) begin
            up  <= dir_sw;
            pre <= '0;
            st  <= RUN;
          end
        end
        DONE: begin
          if (clr_p) begin
            clr        <= 1'b1;
            lap_active <= 1'b0;
            st         <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign {min_out, secmsd_out, seclsd_out, ten_out} = lap_active ? lap_q : live;
  assign dot   = lap_active;
  assign state = st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a behavioural BCD counter driven by en/up/clr
// and a bench-side preload path for reaching corner counts quickly.
module tb_stopwatch_ctrl;
  localparam int TICK_DIV = 4;
  localparam int DEB      = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic start_btn = 1'b0, lap_btn = 1'b0, clr_btn = 1'b0, dir_sw = 1'b1;
  logic [15:0] cnt = '0;
  logic [15:0] load_val = '0;
  logic        load_req = 1'b0;
  logic        en, up, clr, dot;
  logic [3:0]  min_out, secmsd_out, seclsd_out, ten_out;
  logic [1:0]  state;
  logic [15:0] disp;

  assign disp = {min_out, secmsd_out, seclsd_out, ten_out};

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset),
    .start_btn(start_btn), .lap_btn(lap_btn), .clr_btn(clr_btn), .dir_sw(dir_sw),
    .min_in(cnt[15:12]), .secmsd_in(cnt[11:8]), .seclsd_in(cnt[7:4]), .ten_in(cnt[3:0]),
    .en(en), .up(up), .clr(clr),
    .min_out(min_out), .secmsd_out(secmsd_out), .seclsd_out(seclsd_out), .ten_out(ten_out),
    .dot(dot), .state(state)
  );

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] m, sm, sl, t;
    {m, sm, sl, t} = v;
    if (t != 4'd9) t = t + 4'd1;
    else begin
      t = 4'd0;
      if (sl != 4'd9) sl = sl + 4'd1;
      else begin
        sl = 4'd0;
        if (sm != 4'd5) sm = sm + 4'd1;
        else begin
          sm = 4'd0;
          m  = (m == 4'd9) ? 4'd0 : m + 4'd1;
        end
      end
    end
    return {m, sm, sl, t};
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m, sm, sl, t;
    {m, sm, sl, t} = v;
    if (t != 4'd0) t = t - 4'd1;
    else begin
      t = 4'd9;
      if (sl != 4'd0) sl = sl - 4'd1;
      else begin
        sl = 4'd9;
        if (sm != 4'd0) sm = sm - 4'd1;
        else begin
          sm = 4'd5;
          m  = (m == 4'd0) ? 4'd9 : m - 4'd1;
        end
      end
    end
    return {m, sm, sl, t};
  endfunction

  always @(posedge clk) begin
    if (load_req)   cnt <= load_val;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= up ? bcd_inc(cnt) : bcd_dec(cnt);
  end

  int en_cnt = 0, clr_cnt = 0;
  always @(negedge clk) begin
    if (en === 1'b1)  en_cnt  <= en_cnt + 1;
    if (clr === 1'b1) clr_cnt <= clr_cnt + 1;
  end

  // scoreboard
  int checks = 0, errors = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic expect_pop(input string name, input logic [15:0] act);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty actual=%0h", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'(act), 32'(e));
    end
  endtask

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: start_btn = v;
      1: lap_btn   = v;
      default: clr_btn = v;
    endcase
  endtask

  // Returns just after the edge on which the FSM acts on the press.
  task automatic press_act(input int which);
    set_btn(which, 1'b1);
    cyc(DEB + 4);
    set_btn(which, 1'b0);
  endtask

  task automatic load(input logic [15:0] v);
    load_val = v;
    load_req = 1'b1;
    cyc(1);
    load_req = 1'b0;
  endtask

  task automatic back_to_idle();
    cyc(5);
    press_act(0);
    cyc(5);
    press_act(2);
    cyc(5);
  endtask

  typedef struct {
    logic [15:0] digits;
    logic        dir;
    logic [1:0]  exp_state;
    logic        exp_up;
  } vec_t;

  vec_t vecs[8];
  int   e0, c0;

  initial begin
    vecs[0] = '{16'h9599, 1'b1, 2'd0, 1'b1};
    vecs[1] = '{16'h9599, 1'b0, 2'd1, 1'b0};
    vecs[2] = '{16'h0000, 1'b0, 2'd0, 1'b0};
    vecs[3] = '{16'h0000, 1'b1, 2'd1, 1'b1};
    vecs[4] = '{16'h9598, 1'b1, 2'd1, 1'b1};
    vecs[5] = '{16'h5999, 1'b1, 2'd1, 1'b1};
    vecs[6] = '{16'h0001, 1'b0, 2'd1, 1'b0};
    vecs[7] = '{16'h0010, 1'b0, 2'd1, 1'b0};

    // reset behaviour
    cyc(1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_up", 32'(up), 32'd1);
    chk("rst_dot", 32'(dot), 32'd0);
    chk("rst_clr_high", 32'(clr), 32'd1);
    cyc(2);
    chk("rst_clr_still_high", 32'(clr), 32'd1);
    reset = 1'b0;
    cyc(1);
    chk("rst_clr_drop", 32'(clr), 32'd0);
    cyc(5);

    // start-acceptance table from IDLE: terminal check against dir_sw
    for (int i = 0; i < 8; i++) begin
      load(vecs[i].digits);
      dir_sw = vecs[i].dir;
      expect_push({12'd0, vecs[i].exp_state, 1'b0, vecs[i].exp_up});
      press_act(0);
      expect_pop($sformatf("vec%0d_state_up", i), {12'd0, state, 1'b0, up});
      if (vecs[i].exp_state == 2'd1) back_to_idle();
      else cyc(5);
    end
    chk("table_end_idle", 32'(state), 32'd0);
    chk("table_end_cnt", 32'(cnt), 32'h0000);

    // bounce then stable start press
    dir_sw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_btn = (i % 2 == 0);
      cyc(1);
    end
    start_btn = 1'b1;
    cyc(DEB + 3);
    chk("bounce_not_yet_run", 32'(state), 32'd0);
    cyc(1);
    chk("bounce_run", 32'(state), 32'd1);
    cyc(TICK_DIV - 1);
    chk("first_en_early", 32'(en), 32'd0);
    cyc(1);
    chk("first_en", 32'(en), 32'd1);
    cyc(1);
    chk("en_one_cycle", 32'(en), 32'd0);
    cyc(TICK_DIV - 1);
    chk("second_en", 32'(en), 32'd1);
    cyc(6);
    start_btn = 1'b0;
    e0 = en_cnt;
    expect_push(16'd5);
    cyc(20);
    expect_pop("hold_en_count", 16'(en_cnt - e0));
    chk("hold_single_press", 32'(state), 32'd1);

    // up run to terminal
    press_act(0);
    chk("pause_state", 32'(state), 32'd2);
    cyc(5);
    load(16'h9598);
    dir_sw = 1'b1;
    press_act(0);
    chk("resume_run", 32'(state), 32'd1);
    e0 = en_cnt;
    cyc(TICK_DIV - 1);
    chk("resume_en_early", 32'(en), 32'd0);
    cyc(1);
    chk("resume_en", 32'(en), 32'd1);
    cyc(1);
    chk("cnt_9599", 32'(cnt), 32'h9599);
    cyc(TICK_DIV - 1);
    chk("done_state", 32'(state), 32'd3);
    chk("done_no_en", 32'(en), 32'd0);
    cyc(4);
    chk("done_en_count", 32'(en_cnt - e0), 32'd1);
    press_act(0);
    chk("done_start_ignored", 32'(state), 32'd3);
    cyc(5);
    press_act(2);
    chk("done_clr_pulse", 32'(clr), 32'd1);
    chk("done_clr_idle", 32'(state), 32'd0);
    cyc(1);
    chk("done_clr_single", 32'(clr), 32'd0);
    chk("done_cnt_cleared", 32'(cnt), 32'h0000);
    cyc(5);

    // down direction
    dir_sw = 1'b0;
    press_act(0);
    chk("down_zero_ignored", 32'(state), 32'd0);
    cyc(5);
    dir_sw = 1'b1;
    press_act(0);
    cyc(5);
    press_act(0);
    chk("down_paused", 32'(state), 32'd2);
    cyc(5);
    load(16'h0003);
    dir_sw = 1'b0;
    press_act(0);
    chk("down_run", 32'(state), 32'd1);
    chk("down_up_latched", 32'(up), 32'd0);
    e0 = en_cnt;
    cyc(4 * TICK_DIV - 1);
    chk("down_still_run", 32'(state), 32'd1);
    cyc(1);
    chk("down_done", 32'(state), 32'd3);
    chk("down_done_no_en", 32'(en), 32'd0);
    cyc(2);
    chk("down_en_count", 32'(en_cnt - e0), 32'd3);
    chk("down_cnt_zero", 32'(cnt), 32'h0000);
    cyc(3);
    press_act(2);
    chk("down_clr_idle", 32'(state), 32'd0);
    cyc(5);

    // lap hold
    dir_sw = 1'b1;
    load(16'h0124);
    start_btn = 1'b1;
    cyc(1);
    lap_btn = 1'b1;
    cyc(DEB + 3);
    chk("lap_run", 32'(state), 32'd1);
    start_btn = 1'b0;
    cyc(1);
    lap_btn = 1'b0;
    chk("lap_dot_on", 32'(dot), 32'd1);
    chk("lap_frozen_0", 32'(disp), 32'h0124);
    cyc(TICK_DIV);
    chk("lap_live_moves", 32'(cnt), 32'h0125);
    chk("lap_frozen_1", 32'(disp), 32'h0124);
    cyc(TICK_DIV);
    chk("lap_frozen_2", 32'(disp), 32'h0124);
    press_act(1);
    chk("lap_dot_off", 32'(dot), 32'd0);
    chk("lap_tracks_live", 32'(disp), 32'h0127);

    // clr+start in PAUSED, then clr in RUN
    cyc(5);
    press_act(1);
    chk("lap2_dot_on", 32'(dot), 32'd1);
    cyc(5);
    press_act(0);
    chk("pri_paused", 32'(state), 32'd2);
    cyc(5);
    start_btn = 1'b1;
    clr_btn = 1'b1;
    cyc(DEB + 4);
    start_btn = 1'b0;
    clr_btn = 1'b0;
    chk("pri_clr_pulse", 32'(clr), 32'd1);
    chk("pri_idle", 32'(state), 32'd0);
    chk("pri_lap_cleared", 32'(dot), 32'd0);
    cyc(1);
    chk("pri_no_run", 32'(state), 32'd0);
    chk("pri_clr_single", 32'(clr), 32'd0);
    cyc(5);
    press_act(0);
    chk("run_again", 32'(state), 32'd1);
    cyc(5);
    c0 = clr_cnt;
    press_act(2);
    chk("run_clr_ignored", 32'(state), 32'd1);
    cyc(3);
    chk("run_no_clr_pulse", 32'(clr_cnt - c0), 32'd0);

    // mid-operation reset
    cyc(2);
    press_act(1);
    chk("mid_lap_on", 32'(dot), 32'd1);
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_en", 32'(en), 32'd0);
    chk("mid_rst_up", 32'(up), 32'd1);
    chk("mid_rst_dot", 32'(dot), 32'd0);
    chk("mid_rst_clr", 32'(clr), 32'd1);
    reset = 1'b0;
    cyc(1);
    chk("mid_rst_clr_drop", 32'(clr), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
